// File: rtl/compare_2_checker.sv
// compare_2_checker
//
// Built-in self-test sequencer for a 2-bit magnitude comparator. On a
// start pulse it drives all 16 operand codes {A1,A0,B1,B0} in order. Each
// code is held for SETTLE+1 cycles, and then the comparator flags are
// checked against the golden {A<B, A>B, A==B}. It reports pass/fail, a
// saturating error count and the first failing code.
//
// Parameters
//   SETTLE    : wait cycles between applying a vector and sampling (0..15)
//
// Ports
//   clk                    : clock, rising edge
//   rst_n                  : asynchronous active-low reset
//   start                  : single-cycle run request (ignored while busy)
//   A1,A0 / B1,B0          : registered operand outputs (A1/B1 are MSBs)
//   A_lt_B,A_gt_B,A_eq_B   : comparator flags under test
//   busy                   : run in progress
//   done                   : run finished; results valid until next start
//   pass                   : done with zero errors
//   err_cnt                : number of failing vectors, saturates at 16
//   fail_vld               : a failing vector has been captured
//   fail_code              : {A1,A0,B1,B0} of the first failing vector
//
// Optional feature macro
//   COMPARE_2_CHK_STOP_ON_FAIL_EN : when defined, the first mismatch ends
//   the run immediately (err_cnt = 1, remaining vectors skipped).

module compare_2_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A1,
  output logic       A0,
  output logic       B1,
  output logic       B0,
  input  logic       A_lt_B,
  input  logic       A_gt_B,
  input  logic       A_eq_B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       fail_vld,
  output logic [3:0] fail_code
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [4:0] ERR_MAX  = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Golden comparator result for a 4-bit code {A1,A0,B1,B0}.
  function automatic logic [2:0] golden(input logic [3:0] code);
    logic [1:0] a;
    logic [1:0] b;
    a = code[3:2];
    b = code[1:0];
    return {(a < b), (a > b), (a == b)};
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + 5'd1;
  endfunction

  state_e     state_q, state_d;
  // code_q doubles as the operand register: it is held at 0 outside RUN.
  logic [3:0] code_q, code_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [4:0] err_q, err_d;
  logic       fail_vld_q, fail_vld_d;
  logic [3:0] fail_code_q, fail_code_d;

  logic [2:0] flags;
  logic       sample;
  logic       mismatch;
  logic       finish;

  assign flags    = {A_lt_B, A_gt_B, A_eq_B};
  assign sample   = (state_q == RUN) && (cnt_q == SETTLE_C);
  assign mismatch = sample && (flags != golden(code_q));

`ifdef COMPARE_2_CHK_STOP_ON_FAIL_EN
  assign finish = sample && ((code_q == 4'hF) || mismatch);
`else
  assign finish = sample && (code_q == 4'hF);
`endif

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    fail_vld_d  = fail_vld_q;
    fail_code_d = fail_code_q;

    case (state_q)
      IDLE, DONE: begin
        // A new run from DONE is identical to leaving IDLE.
        if (start) begin
          state_d     = RUN;
          code_d      = 4'd0;
          cnt_d       = 4'd0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 5'd0;
          fail_vld_d  = 1'b0;
          fail_code_d = 4'd0;
        end
      end

      RUN: begin
        if (!sample) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd0;
          if (mismatch) begin
            err_d = sat_inc(err_q);
            if (!fail_vld_q) begin
              fail_vld_d  = 1'b1;
              fail_code_d = code_q;
            end
          end
          if (finish) begin
            state_d = DONE;
            code_d  = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            code_d = code_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        code_d  = 4'd0;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= 4'd0;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 5'd0;
      fail_vld_q  <= 1'b0;
      fail_code_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fail_vld_q  <= fail_vld_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign {A1, A0, B1, B0} = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Decoded from registers only, so no flag-to-output combinational path.
  assign pass      = done_q && (err_q == 5'd0);
  assign err_cnt   = err_q;
  assign fail_vld  = fail_vld_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_compare_2_checker.sv
module tb_compare_2_checker;

  localparam int S = 2;
  localparam int P = S + 1;
`ifdef COMPARE_2_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       A1, A0, B1, B0;
  logic       A_lt_B, A_gt_B, A_eq_B;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic       fail_vld;
  logic [3:0] fail_code;

  int checks   = 0;
  int failures = 0;

  // Comparator behaviour for each of the 16 codes, 3 bits per code.
  logic [47:0] resp_tbl;

  compare_2_checker #(.SETTLE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A1        (A1),
    .A0        (A0),
    .B1        (B1),
    .B0        (B0),
    .A_lt_B    (A_lt_B),
    .A_gt_B    (A_gt_B),
    .A_eq_B    (A_eq_B),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_vld  (fail_vld),
    .fail_code (fail_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] op_code;
  assign op_code = {A1, A0, B1, B0};
  assign {A_lt_B, A_gt_B, A_eq_B} = resp_tbl[op_code*3 +: 3];

  // Reference comparator result from integer arithmetic.
  function automatic logic [2:0] ref_flags(input int c);
    int a;
    int b;
    a = c / 4;
    b = c % 4;
    return {(a < b) ? 1'b1 : 1'b0, (a > b) ? 1'b1 : 1'b0, (a == b) ? 1'b1 : 1'b0};
  endfunction

  // mode 0: correct, 1: A_eq_B stuck 0, 2: lt/gt swapped, 3: random faults
  task automatic set_mode(input int m);
    logic [2:0] r;
    for (int c = 0; c < 16; c++) begin
      r = ref_flags(c);
      case (m)
        1: r[0] = 1'b0;
        2: r = {r[1], r[2], r[0]};
        3: if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
        default: ;
      endcase
      resp_tbl[c*3 +: 3] = r;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ops"},       32'(op_code),   32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " done"},      32'(done),      32'd0);
    check({tag, " pass"},      32'(pass),      32'd0);
    check({tag, " err_cnt"},   32'(err_cnt),   32'd0);
    check({tag, " fail_vld"},  32'(fail_vld),  32'd0);
    check({tag, " fail_code"}, 32'(fail_code), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one self-test and checks every cycle against the reference.
  // repulse_j: cycle after start at which start is pulsed again (-1: never)
  // reset_j  : cycle after start at which rst_n is asserted (-1: never)
  task automatic do_run(input int repulse_j, input int reset_j);
    bit fails [16];
    int first;
    int last;
    int total;
    int cnt;
    first = -1;
    for (int c = 0; c < 16; c++) begin
      fails[c] = (resp_tbl[c*3 +: 3] != ref_flags(c));
      if (fails[c] && first < 0) first = c;
    end
    last  = (STOP && first >= 0) ? first : 15;
    total = (last + 1) * P;

    pulse_start();
    for (int j = 0; j < total; j++) begin
      if (j == reset_j) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun reset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      cnt = 0;
      for (int n = 0; n <= last; n++)
        if (fails[n] && (n + 1) * P <= j) cnt++;
      check($sformatf("code j=%0d", j), 32'(op_code), 32'(j / P));
      check($sformatf("busy j=%0d", j), 32'(busy), 32'd1);
      check($sformatf("done j=%0d", j), 32'(done), 32'd0);
      check($sformatf("err_cnt j=%0d", j), 32'(err_cnt), 32'(cnt));
      check($sformatf("fail_vld j=%0d", j), 32'(fail_vld), 32'(cnt > 0));
      if (j == repulse_j) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cnt = 0;
    for (int n = 0; n <= last; n++) if (fails[n]) cnt++;
    if (cnt > 16) cnt = 16;
    check("end busy",      32'(busy),      32'd0);
    check("end done",      32'(done),      32'd1);
    check("end ops",       32'(op_code),   32'd0);
    check("end err_cnt",   32'(err_cnt),   32'(cnt));
    check("end pass",      32'(pass),      32'(cnt == 0));
    check("end fail_vld",  32'(fail_vld),  32'(first >= 0));
    check("end fail_code", 32'(fail_code), (first >= 0) ? 32'(first) : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_mode(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("idle after reset");

    // Correct comparator; start re-pulsed during vector 5 is ignored.
    set_mode(0);
    do_run(5 * P + 1, -1);

    // A_eq_B stuck at 0: codes 0, 5, 10, 15 fail.
    set_mode(1);
    do_run(-1, -1);
    check("eq stuck err_cnt",   32'(err_cnt),   STOP ? 32'd1 : 32'd4);
    check("eq stuck fail_code", 32'(fail_code), 32'd0);
    check("eq stuck pass",      32'(pass),      32'd0);

    // lt/gt swapped: every unequal pair fails, first is A=0,B=1.
    set_mode(2);
    do_run(-1, -1);
    check("swap err_cnt",   32'(err_cnt),   STOP ? 32'd1 : 32'd12);
    check("swap fail_code", 32'(fail_code), 32'd1);

    // Restart from DONE with a correct model: counters clear.
    set_mode(0);
    do_run(-1, -1);

    // Randomized fault patterns.
    for (int r = 0; r < 4; r++) begin
      set_mode(3);
      do_run(-1, -1);
    end

    // Reset during vector 7 with a faulty model, then a clean run.
    set_mode(1);
    do_run(-1, 7 * P + 1);
    @(posedge clk);
    #1;
    check_reset_outputs("idle after midrun reset");
    set_mode(0);
    do_run(-1, -1);
    check("clean after reset pass", 32'(pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/compare_2_checker.md
# compare_2_checker

Hardware self-test sequencer for the 2-bit magnitude comparator. It is the driving end of the comparator interface: it generates the A1/A0/B1/B0 operand bits and samples the A_lt_B/A_gt_B/A_eq_B flags. On `start` it walks all 16 operand codes, checks each flag triple against an internally computed golden result, and reports pass/fail, an error count and the first failing code. It sits beside the comparator in the DCIC lab designs and replaces the exhaustive stimulus loop with synthesizable BIST logic.

## Interface
- `SETTLE`, default 2: wait cycles between applying a vector and sampling the flags; legal range 0..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a run.
- `A1`, `A0` output 1 each: operand A, registered; `A1` is the MSB.
- `B1`, `B0` output 1 each: operand B, registered; `B1` is the MSB.
- `A_lt_B`, `A_gt_B`, `A_eq_B` input 1 each: comparator flags under test.
- `busy` output 1: high while a run is in progress.
- `done` output 1: high from run completion until the next accepted `start` or reset.
- `pass` output 1: `done && err_cnt==0`.
- `err_cnt` output 5: number of failing vectors, 0..16.
- `fail_vld` output 1: at least one failure has been captured this run.
- `fail_code` output 4: `{A1,A0,B1,B0}` of the first failing vector.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:** `start` moves the FSM to RUN, loads vector code 0 and the settle count 0, and clears `err_cnt`, `fail_vld` and `fail_code`.
- **RUN:**
  - The outputs `{A1,A0,B1,B0}` equal the current 4-bit code.
  - The settle counter increments each cycle.
  - When the counter equals `SETTLE`, the flags are sampled and checked. The code then increments and the counter clears.
- **Expected result:** with A={A1,A0} and B={B1,B0} treated as unsigned, expected = {A<B, A>B, A==B}.
- **Mismatch rule:** a vector fails when the sampled `{A_lt_B,A_gt_B,A_eq_B}` differs from expected in any bit. A non-one-hot triple (000, 110, 111, and so on) therefore always fails.
- **On a failure:**
  - `err_cnt` increments and saturates at 16.
  - If `fail_vld` is 0, the current code is stored in `fail_code` and `fail_vld` is set.
- **End of run:** sampling code 15 moves the FSM to DONE.
- **DONE:** the operand outputs are driven to 0 and the results hold. `start` begins a new run, identical to leaving IDLE.
- **`start` while `busy`:** ignored.
- **Operand outputs in IDLE and DONE:** 0.
- **Reset values:** all outputs are 0 (`A1`, `A0`, `B1`, `B0`, `busy`, `done`, `pass`, `err_cnt`, `fail_vld`, `fail_code`) and the state is IDLE.
- **Reset mid-run:** aborts immediately. All outputs return to their reset values and no partial result is retained.

## Timing
- `start` is sampled at edge k. After edge k, `busy`=1 and code 0 is on the outputs.
- Vector n is sampled at edge k+(n+1)·(SETTLE+1). Its flags must be stable for at least SETTLE+1 cycles after the operands change.
- After edge k+16·(SETTLE+1): `busy`=0, `done`=1, and `pass`, `err_cnt` and `fail_*` are final.
  - With SETTLE=2, `done` rises after edge k+48.
  - With SETTLE=0, one vector is checked per cycle and `done` rises after edge k+16.
- `err_cnt` and `fail_*` update on the sampling edge and are visible in the following cycle.
- All outputs are registered. There is no combinational path from the flag inputs to any output except `pass`, which is decoded from registers.

## Configuration
- `COMPARE_2_CHK_STOP_ON_FAIL_EN` defined:
  - The first mismatch moves the FSM from RUN to DONE on that sampling edge.
  - `err_cnt` is 1, `fail_code` holds the failing code, and the remaining vectors are skipped.
  - The operand outputs go to 0 the next cycle.
- `COMPARE_2_CHK_STOP_ON_FAIL_EN` undefined: all 16 vectors always run and every failure is counted.

## Test plan
- **Correct comparator model, SETTLE=2:** pulse `start` at edge k.
  - Required: codes 0..15 each held 3 cycles.
  - Required: `done`=1 after edge k+48, `pass`=1, `err_cnt`=0, `fail_vld`=0.
- **`A_eq_B` stuck at 0:**
  - Required: `err_cnt`=4 (codes 0, 5, 10, 15), `fail_code`=4'b0000, `pass`=0.
- **`A_lt_B` and `A_gt_B` swapped:**
  - Required: `err_cnt`=12, `fail_code`=4'b0001 (A=0, B=1).
- **`start` re-pulsed during the run at vector 5:**
  - Required: no restart, and completion still after edge k+48.
  - Then pulse `start` in DONE. Required: counters clear and a new 48-cycle run begins.
- **`rst_n` low during vector 7 with a faulty model:**
  - Required: all outputs 0 and the FSM in IDLE.
  - Then a clean run with a correct model gives `pass`=1.
- **With `COMPARE_2_CHK_STOP_ON_FAIL_EN`, `A_eq_B` stuck at 0, SETTLE=2:**
  - Required: `done`=1 after edge k+3, `err_cnt`=1, `fail_code`=4'b0000.
